// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared types and helpers for the asynchronous serial link blocks.
//   t_rx_state : receiver FSM state encoding (3 bits; unused codes recover to
//                RX_READY inside the receiver).
//   calc_div   : main-clock cycles per oversample tick, floored, minimum 1.
// -----------------------------------------------------------------------------
package serial_pkg;

  typedef enum logic [2:0] {
    RX_READY   = 3'd0,
    RX_START   = 3'd1,
    RX_DATA    = 3'd2,
    RX_PARITY  = 3'd3,
    RX_STOP    = 3'd4
  } t_rx_state;

  // Integer divide of the main clock by the oversampled baud rate. A result
  // of 0 (baud faster than the clock allows) is clamped to one tick per cycle.
  function automatic int calc_div(input int main_clk_hz,
                                  input int serial_clk_hz,
                                  input int oversample);
    int div;
    div = main_clk_hz / (serial_clk_hz * oversample);
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/serial_oversample_tick.sv
// -----------------------------------------------------------------------------
// serial_oversample_tick
// Free-running divider that emits a one-cycle tick every DIV clock cycles.
// A synchronous clear restarts the count so the next tick lands DIV cycles
// (DIV=1: one cycle) after the clear, aligning ticks to an external event.
// Ports:
//   in_clk    : clock
//   in_rst    : asynchronous active-low reset
//   in_clear  : synchronous restart of the divider (suppresses the tick)
//   out_tick  : one-cycle pulse every DIV cycles
// -----------------------------------------------------------------------------
module serial_oversample_tick #(
  parameter int DIV = 1
) (
  input  logic in_clk,
  input  logic in_rst,
  input  logic in_clear,
  output logic out_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = cnt_q;
    out_tick = 1'b0;
    if (in_clear) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d    = '0;
      out_tick = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_async_rx.sv
// -----------------------------------------------------------------------------
// serial_async_rx
// UART-style receiver running entirely in the main clock domain. The line is
// double-flopped, a start edge phase-aligns an oversample tick counter, and
// each bit is sampled once at its middle tick. Each received word is
// presented with a one-cycle valid strobe plus parity/frame error flags.
// Ports:
//   in_clk          : main clock
//   in_rst          : asynchronous active-low reset
//   in_enable       : receive enable, only consulted while idle
//   in_serial       : asynchronous serial line
//   out_ready       : 1 while no frame is in progress
//   out_word_valid  : one-cycle strobe, out_parallel holds a new word
//   out_parity_err  : parity mismatch on the strobed word (held until next)
//   out_frame_err   : a stop bit was wrong on the strobed word (held)
//   out_parallel    : last received word
// -----------------------------------------------------------------------------
module serial_async_rx
  import serial_pkg::*;
#(
  parameter int   MAIN_CLK_HZ     = 50_000_000,
  parameter int   SERIAL_CLK_HZ   = 9_600,
  parameter int   OVERSAMPLE      = 16,
  parameter logic SERIAL_INACTIVE = 1'b1,
  parameter logic SERIAL_START    = 1'b0,
  parameter logic SERIAL_STOP     = 1'b1,
  parameter int   BITS            = 8,
  parameter int   START_BITS      = 1,
  parameter int   PARITY_BITS     = 0,
  parameter int   STOP_BITS       = 1,
  parameter logic LOWBIT_FIRST    = 1'b1,
  parameter logic EVEN_PARITY     = 1'b1
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_enable,
  input  logic            in_serial,
  output logic            out_ready,
  output logic            out_word_valid,
  output logic            out_parity_err,
  output logic            out_frame_err,
  output logic [BITS-1:0] out_parallel
);

  localparam int DIV      = calc_div(MAIN_CLK_HZ, SERIAL_CLK_HZ, OVERSAMPLE);
  localparam int TCW      = $clog2(OVERSAMPLE);
  localparam int MAX_DS   = (BITS > START_BITS) ? BITS : START_BITS;
  localparam int MAX_BITS = (MAX_DS > STOP_BITS) ? MAX_DS : STOP_BITS;
  localparam int BCW      = $clog2(MAX_BITS) + 1;

  localparam logic [TCW-1:0] TICK_MID   = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0] TICK_LAST  = TCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] START_LAST = BCW'(START_BITS - 1);
  localparam logic [BCW-1:0] DATA_LAST  = BCW'(BITS - 1);
  localparam logic [BCW-1:0] STOP_LAST  = BCW'(STOP_BITS - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  t_rx_state       state_q, state_d;
  logic [TCW-1:0]  tick_ctr_q, tick_ctr_d;
  logic [BCW-1:0]  bit_ctr_q, bit_ctr_d;
  logic [BITS-1:0] data_q, data_d;
  logic            par_acc_q, par_acc_d;
  logic            par_pend_q, par_pend_d;
  logic            frm_pend_q, frm_pend_d;
  logic            armed_q, armed_d;
  logic            valid_q, valid_d;
  logic [BITS-1:0] parallel_q, parallel_d;
  logic            par_err_q, par_err_d;
  logic            frm_err_q, frm_err_d;

  logic            tick;
  logic            tick_clear;
  logic            mid_tick;
  logic            end_tick;
  logic            par_expected;
  logic [BCW-1:0]  data_pos;

  serial_oversample_tick #(
    .DIV(DIV)
  ) u_tick (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .in_clear (tick_clear),
    .out_tick (tick)
  );

  always_comb begin
    sync1_d      = in_serial;
    sync2_d      = sync1_q;
    state_d      = state_q;
    tick_ctr_d   = tick_ctr_q;
    bit_ctr_d    = bit_ctr_q;
    data_d       = data_q;
    par_acc_d    = par_acc_q;
    par_pend_d   = par_pend_q;
    frm_pend_d   = frm_pend_q;
    armed_d      = armed_q;
    valid_d      = 1'b0;
    parallel_d   = parallel_q;
    par_err_d    = par_err_q;
    frm_err_d    = frm_err_q;
    tick_clear   = 1'b0;

    mid_tick     = tick && (tick_ctr_q == TICK_MID);
    end_tick     = tick && (tick_ctr_q == TICK_LAST);
    // par_acc tracks odd/even count of data ones; the parity bit completes it.
    par_expected = EVEN_PARITY ? par_acc_q : ~par_acc_q;
    data_pos     = LOWBIT_FIRST ? bit_ctr_q : (DATA_LAST - bit_ctr_q);

    if (tick) begin
      tick_ctr_d = end_tick ? '0 : tick_ctr_q + TCW'(1);
    end

    case (state_q)
      RX_READY: begin
        tick_ctr_d = '0;
        bit_ctr_d  = '0;
        // A start is only accepted after the line has been idle at least once
        // while waiting, so a line stuck low after a bad stop bit is ignored.
        if (sync2_q == SERIAL_INACTIVE) begin
          armed_d = 1'b1;
        end
        if (in_enable && armed_q && (sync2_q == SERIAL_START)) begin
          state_d    = RX_START;
          tick_clear = 1'b1;
          armed_d    = 1'b0;
          par_acc_d  = 1'b0;
          par_pend_d = 1'b0;
          frm_pend_d = 1'b0;
        end
      end

      RX_START: begin
        if (mid_tick && (sync2_q != SERIAL_START)) begin
          // Too short to be a start bit: drop silently.
          state_d = RX_READY;
        end else if (end_tick) begin
          if (bit_ctr_q == START_LAST) begin
            bit_ctr_d = '0;
            state_d   = RX_DATA;
          end else begin
            bit_ctr_d = bit_ctr_q + BCW'(1);
          end
        end
      end

      RX_DATA: begin
        if (mid_tick) begin
          for (int i = 0; i < BITS; i++) begin
            if (data_pos == BCW'(i)) begin
              data_d[i] = sync2_q;
            end
          end
          if (sync2_q) begin
            par_acc_d = ~par_acc_q;
          end
        end
        if (end_tick) begin
          if (bit_ctr_q == DATA_LAST) begin
            bit_ctr_d = '0;
            state_d   = (PARITY_BITS != 0) ? RX_PARITY : RX_STOP;
          end else begin
            bit_ctr_d = bit_ctr_q + BCW'(1);
          end
        end
      end

      RX_PARITY: begin
        if (mid_tick && (sync2_q != par_expected)) begin
          par_pend_d = 1'b1;
        end
        if (end_tick) begin
          bit_ctr_d = '0;
          state_d   = RX_STOP;
        end
      end

      RX_STOP: begin
        if (mid_tick) begin
          if (bit_ctr_q == STOP_LAST) begin
            // Deliver at the middle of the last stop bit and go idle right
            // away so a start bit immediately following is not missed.
            valid_d    = 1'b1;
            parallel_d = data_q;
            par_err_d  = par_pend_q;
            frm_err_d  = frm_pend_q | (sync2_q != SERIAL_STOP);
            state_d    = RX_READY;
          end else if (sync2_q != SERIAL_STOP) begin
            frm_pend_d = 1'b1;
          end
        end
        if (end_tick) begin
          bit_ctr_d = bit_ctr_q + BCW'(1);
        end
      end

      default: begin
        state_d = RX_READY;
      end
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      sync1_q    <= SERIAL_INACTIVE;
      sync2_q    <= SERIAL_INACTIVE;
      state_q    <= RX_READY;
      tick_ctr_q <= '0;
      bit_ctr_q  <= '0;
      data_q     <= '0;
      par_acc_q  <= 1'b0;
      par_pend_q <= 1'b0;
      frm_pend_q <= 1'b0;
      armed_q    <= 1'b0;
      valid_q    <= 1'b0;
      parallel_q <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      state_q    <= state_d;
      tick_ctr_q <= tick_ctr_d;
      bit_ctr_q  <= bit_ctr_d;
      data_q     <= data_d;
      par_acc_q  <= par_acc_d;
      par_pend_q <= par_pend_d;
      frm_pend_q <= frm_pend_d;
      armed_q    <= armed_d;
      valid_q    <= valid_d;
      parallel_q <= parallel_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
    end
  end

  assign out_ready      = (state_q == RX_READY);
  assign out_word_valid = valid_q;
  assign out_parity_err = par_err_q;
  assign out_frame_err  = frm_err_q;
  assign out_parallel   = parallel_q;

endmodule

// File: tb/tb_serial_async_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_async_rx
// Three receivers at 16 clocks per bit: A = 8N1 LSB-first, B = 8N1 MSB-first,
// C = 8E1 LSB-first. Frames are driven on the line bit by bit; a monitor
// records every strobe and the directed sequence compares against values
// computed from the frame contents.
// -----------------------------------------------------------------------------
module tb_serial_async_rx;

  localparam int CPB = 16;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic enable = 1'b0;
  logic ser_a  = 1'b1;
  logic ser_b  = 1'b1;
  logic ser_c  = 1'b1;

  logic       rdy_a, vld_a, pe_a, fe_a;
  logic       rdy_b, vld_b, pe_b, fe_b;
  logic       rdy_c, vld_c, pe_c, fe_c;
  logic [7:0] par_a, par_b, par_c;

  always #5 clk = ~clk;

  serial_async_rx #(
    .MAIN_CLK_HZ(16_000_000), .SERIAL_CLK_HZ(1_000_000), .OVERSAMPLE(16)
  ) dut_a (
    .in_clk(clk), .in_rst(rst_n), .in_enable(enable), .in_serial(ser_a),
    .out_ready(rdy_a), .out_word_valid(vld_a), .out_parity_err(pe_a),
    .out_frame_err(fe_a), .out_parallel(par_a)
  );

  serial_async_rx #(
    .MAIN_CLK_HZ(16_000_000), .SERIAL_CLK_HZ(1_000_000), .OVERSAMPLE(16),
    .LOWBIT_FIRST(1'b0)
  ) dut_b (
    .in_clk(clk), .in_rst(rst_n), .in_enable(enable), .in_serial(ser_b),
    .out_ready(rdy_b), .out_word_valid(vld_b), .out_parity_err(pe_b),
    .out_frame_err(fe_b), .out_parallel(par_b)
  );

  serial_async_rx #(
    .MAIN_CLK_HZ(16_000_000), .SERIAL_CLK_HZ(1_000_000), .OVERSAMPLE(16),
    .PARITY_BITS(1), .EVEN_PARITY(1'b1)
  ) dut_c (
    .in_clk(clk), .in_rst(rst_n), .in_enable(enable), .in_serial(ser_c),
    .out_ready(rdy_c), .out_word_valid(vld_c), .out_parity_err(pe_c),
    .out_frame_err(fe_c), .out_parallel(par_c)
  );

  typedef struct {
    logic [7:0] word;
    logic       pe;
    logic       fe;
    int         t;
  } rx_t;

  rx_t q_a[$];
  rx_t q_b[$];
  rx_t q_c[$];

  int cyc = 0;
  int t_start = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc++;

  // Record every strobe cycle; a strobe longer than one cycle shows up as
  // extra entries.
  always @(negedge clk) begin
    rx_t r;
    if (vld_a === 1'b1) begin
      r.word = par_a; r.pe = pe_a; r.fe = fe_a; r.t = cyc; q_a.push_back(r);
    end
    if (vld_b === 1'b1) begin
      r.word = par_b; r.pe = pe_b; r.fe = fe_b; r.t = cyc; q_b.push_back(r);
    end
    if (vld_c === 1'b1) begin
      r.word = par_c; r.pe = pe_c; r.fe = fe_c; r.t = cyc; q_c.push_back(r);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: MSB-first receiver puts the first line bit at the top.
  function automatic logic [7:0] msb_first_value(input logic [7:0] line_bits);
    int v;
    v = 0;
    for (int i = 0; i < 8; i++) v = v * 2 + int'(line_bits[i]);
    return 8'(v);
  endfunction

  // Reference: even parity holds when data ones plus parity bit is even.
  function automatic logic even_parity_bad(input logic [7:0] w, input logic p);
    return ((($countones(w) + int'(p)) % 2) != 0);
  endfunction

  task automatic set_line(input int sel, input logic v);
    case (sel)
      0:       ser_a = v;
      1:       ser_b = v;
      default: ser_c = v;
    endcase
  endtask

  task automatic hold(input int sel, input logic v, input int n);
    set_line(sel, v);
    repeat (n) @(negedge clk);
  endtask

  // line_bits[0] goes on the wire first.
  task automatic send_frame(input int sel, input logic [7:0] line_bits,
                            input bit has_par, input logic pbit, input logic stop);
    t_start = cyc;
    hold(sel, 1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(sel, line_bits[i], CPB);
    if (has_par) hold(sel, pbit, CPB);
    hold(sel, stop, CPB);
  endtask

  function automatic int qsize(input int sel);
    case (sel)
      0:       return q_a.size();
      1:       return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  task automatic expect_one(input string tag, input int sel, input logic [7:0] w,
                            input logic pe, input logic fe);
    rx_t r;
    int  n;
    n = qsize(sel);
    chk({tag, "_strobes"}, 32'(n), 32'd1);
    if (n >= 1) begin
      case (sel)
        0:       r = q_a[0];
        1:       r = q_b[0];
        default: r = q_c[0];
      endcase
      chk({tag, "_word"}, {24'd0, r.word}, {24'd0, w});
      chk({tag, "_perr"}, {31'd0, r.pe}, {31'd0, pe});
      chk({tag, "_ferr"}, {31'd0, r.fe}, {31'd0, fe});
    end
    q_a.delete(); q_b.delete(); q_c.delete();
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] lb;
    logic       pb;
    int         lat;
    int         t0;

    // ---- reset state ----
    repeat (4) @(negedge clk);
    chk("rst_ready", {31'd0, rdy_a}, 32'd1);
    chk("rst_valid", {31'd0, vld_a}, 32'd0);
    chk("rst_perr",  {31'd0, pe_a},  32'd0);
    chk("rst_ferr",  {31'd0, fe_a},  32'd0);
    chk("rst_word",  {24'd0, par_a}, 32'd0);
    rst_n  = 1'b1;
    enable = 1'b1;
    repeat (8) @(negedge clk);

    // ---- 8N1 0xA5 with latency ----
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    hold(0, 1'b1, CPB);
    lat = (q_a.size() > 0) ? (q_a[0].t - t_start) : -1;
    $display("frame A 0xA5: latency %0d cycles", lat);
    chk("a5_latency", {31'd0, (lat >= 153 && lat <= 155)}, 32'd1);
    expect_one("a5", 0, 8'hA5, 1'b0, 1'b0);

    // ---- random LSB-first words ----
    repeat (4) begin
      w = 8'($urandom);
      send_frame(0, w, 1'b0, 1'b0, 1'b1);
      hold(0, 1'b1, CPB);
      $display("frame A rand 0x%02h", w);
      expect_one("a_rand", 0, w, 1'b0, 1'b0);
    end

    // ---- MSB-first ----
    lb = 8'b1010_0101;  // wire order 1,0,1,0,0,1,0,1
    send_frame(1, lb, 1'b0, 1'b0, 1'b1);
    hold(1, 1'b1, CPB);
    $display("frame B msb-first line bits -> expect 0x%02h", msb_first_value(lb));
    expect_one("b_a5", 1, 8'hA5, 1'b0, 1'b0);
    repeat (3) begin
      lb = 8'($urandom);
      send_frame(1, lb, 1'b0, 1'b0, 1'b1);
      hold(1, 1'b1, CPB);
      $display("frame B rand -> expect 0x%02h", msb_first_value(lb));
      expect_one("b_rand", 1, msb_first_value(lb), 1'b0, 1'b0);
    end

    // ---- even parity ----
    send_frame(2, 8'h07, 1'b1, 1'b0, 1'b1);
    hold(2, 1'b1, CPB);
    $display("frame C 0x07 wrong parity");
    expect_one("c_07", 2, 8'h07, 1'b1, 1'b0);
    repeat (4) begin
      w  = 8'($urandom);
      pb = 1'($urandom_range(0, 1));
      send_frame(2, w, 1'b1, pb, 1'b1);
      hold(2, 1'b1, CPB);
      $display("frame C rand 0x%02h parity bit %0d", w, pb);
      expect_one("c_rand", 2, w, even_parity_bad(w, pb), 1'b0);
    end

    // ---- frame error, line stuck low afterwards ----
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    hold(0, 1'b0, 200);
    $display("frame A 0x3C bad stop, line held low");
    chk("stuck_ready", {31'd0, rdy_a}, 32'd1);
    expect_one("a_3c", 0, 8'h3C, 1'b0, 1'b1);
    hold(0, 1'b1, CPB);
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    hold(0, 1'b1, CPB);
    $display("frame A 0x11 after idle");
    expect_one("a_11", 0, 8'h11, 1'b0, 1'b0);

    // ---- 4-cycle glitch ----
    hold(0, 1'b0, 4);
    set_line(0, 1'b1);
    repeat (2) @(negedge clk);
    chk("glitch_busy", {31'd0, rdy_a}, 32'd0);
    repeat (10) @(negedge clk);
    chk("glitch_ready", {31'd0, rdy_a}, 32'd1);
    repeat (200) @(negedge clk);
    $display("glitch on A");
    chk("glitch_nostrobe", 32'(q_a.size()), 32'd0);

    // ---- back-to-back ----
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'hAA, 1'b0, 1'b0, 1'b1);
    hold(0, 1'b1, CPB);
    $display("frames A 0x55,0xAA back to back");
    chk("b2b_strobes", 32'(q_a.size()), 32'd2);
    if (q_a.size() >= 2) begin
      chk("b2b_word0", {24'd0, q_a[0].word}, 32'h55);
      chk("b2b_word1", {24'd0, q_a[1].word}, 32'hAA);
      chk("b2b_gap",   32'(q_a[1].t - q_a[0].t), 32'd160);
    end
    q_a.delete();

    // ---- enable low ----
    enable = 1'b0;
    hold(0, 1'b1, 8);
    send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1);
    hold(0, 1'b1, 2 * CPB);
    $display("frame A 0x12 with enable low");
    chk("dis_nostrobe", 32'(q_a.size()), 32'd0);
    chk("dis_ready", {31'd0, rdy_a}, 32'd1);
    enable = 1'b1;
    hold(0, 1'b1, CPB);

    // ---- reset during 4th data bit of 0xFF ----
    t0 = cyc;
    hold(0, 1'b0, CPB);
    repeat (3) hold(0, 1'b1, CPB);
    hold(0, 1'b1, CPB / 2);
    chk("midrst_busy", {31'd0, rdy_a}, 32'd0);
    rst_n = 1'b0;
    #1;
    $display("reset asserted %0d cycles into frame 0xFF", cyc - t0);
    chk("midrst_ready", {31'd0, rdy_a}, 32'd1);
    chk("midrst_valid", {31'd0, vld_a}, 32'd0);
    chk("midrst_word",  {24'd0, par_a}, 32'd0);
    chk("midrst_perr",  {31'd0, pe_a},  32'd0);
    chk("midrst_ferr",  {31'd0, fe_a},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hold(0, 1'b1, 2 * CPB);
    chk("midrst_nostrobe", 32'(q_a.size()), 32'd0);
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
    hold(0, 1'b1, CPB);
    $display("frame A 0x81 after reset");
    expect_one("a_81", 0, 8'h81, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
